scan_display_n: RTL and testbench

Parametrised time-multiplexed driver for common-anode multi-digit displays. It scans DIGITS digit codes onto one shared data bus and drives an active-low one-cold digit-enable bus. It adds the following to the fixed 4-digit scanner:
- a built-in scan prescaler
- anti-ghosting dead-time between digits
- frame-coherent input snapshot
- per-digit blank mask
- leading-zero suppression

It sits between the value-formatting logic and the segment decoder / board pins.

---
 rtl/scan_display_n.sv | 122 ++++++++++++
 tb/tb_scan_display_n.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_display_n.sv
// rtl/scan_display_n.sv - time-multiplexed common-anode display scanner with dead-time, snapshot, mask and LZ blanking
//
// Parameters:
//   DIGITS  number of multiplexed digits (2..16)
//   DW      width of one digit code
//   DIV     clk cycles per digit slot (>= 2)
//   BLANK   dark cycles at the start of every slot (1 <= BLANK < DIV)
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   en           scan enable; low freezes the scan position and darkens the display
//   din          digit codes, digit k at din[k*DW +: DW]
//   dmask        per-digit show enable (1 = show)
//   lz_en        leading-zero suppression enable
//   Dout         code of the digit currently lit, 0 when dark
//   Eout         active-low one-cold digit enable, digit k on Eout[DIGITS-1-k]
//   frame_start  one-cycle pulse the cycle after a new snapshot is taken

module scan_display_n #(
  parameter int DIGITS = 4,
  parameter int DW     = 4,
  parameter int DIV    = 1000,
  parameter int BLANK  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIGITS*DW-1:0] din,
  input  logic [DIGITS-1:0]    dmask,
  input  logic                 lz_en,
  output logic [DW-1:0]        Dout,
  output logic [DIGITS-1:0]    Eout,
  output logic                 frame_start
);

  localparam int PW = $clog2(DIV);
  localparam int KW = $clog2(DIGITS);

  // scan position: prescaler within the slot and digit index
  logic [PW-1:0] p;
  logic [KW-1:0] k;

  // frame-coherent copies of the inputs, only refreshed at the top of a frame
  logic [DIGITS*DW-1:0] din_s;
  logic [DIGITS-1:0]    dmask_s;
  logic [DIGITS-1:0]    lz_s;

  logic                 p_last;
  logic                 k_last;
  logic                 snap;
  logic                 lit;
  logic [DIGITS-1:0]    lz_next;
  logic [DIGITS-1:0]    eout_next;
  logic                 above_zero;
  logic                 digit_zero;

  assign p_last = (p == PW'(DIV - 1));
  assign k_last = (k == KW'(DIGITS - 1));
  assign snap   = en && (p == '0) && (k == '0);

  // A digit is a leading zero when it and every digit above it are zero.
  // Walk from the most significant digit down, carrying "all above are zero".
  // Digit 0 is never suppressed so a zero value still shows a single 0.
  always_comb begin
    lz_next    = '0;
    above_zero = 1'b1;
    digit_zero = 1'b0;
    for (int j = DIGITS - 1; j >= 1; j--) begin
      digit_zero = (din[j*DW +: DW] == '0);
      lz_next[j] = lz_en && digit_zero && above_zero;
      above_zero = above_zero && digit_zero;
    end
  end

  // The first BLANK cycles of each slot stay dark so the previous digit's
  // anode can turn off before the shared data bus changes (anti-ghosting).
  assign lit = en && (p >= PW'(BLANK)) && dmask_s[k] && !lz_s[k];

  always_comb begin
    eout_next = '1;
    if (lit) begin
      eout_next[KW'(DIGITS - 1) - k] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p           <= '0;
      k           <= '0;
      din_s       <= '0;
      dmask_s     <= '0;
      lz_s        <= '0;
      Dout        <= '0;
      Eout        <= '1;
      frame_start <= 1'b0;
    end else begin
      // position advance; en low holds the position
      if (en) begin
        if (p_last) begin
          p <= '0;
          k <= k_last ? '0 : k + 1'b1;
        end else begin
          p <= p + 1'b1;
        end
      end

      // snapshot at the top of the frame; the slot-0 dead time guarantees
      // the new shadows are in place before slot 0 lights
      if (snap) begin
        din_s   <= din;
        dmask_s <= dmask;
        lz_s    <= lz_next;
      end
      frame_start <= snap;

      // outputs decoded from the pre-edge position and shadows
      Eout <= eout_next;
      Dout <= lit ? din_s[k*DW +: DW] : '0;
    end
  end

endmodule

// File: tb/tb_scan_display_n.sv
// tb/tb_scan_display_n.sv - directed table-driven bench for scan_display_n

module tb_scan_display_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] din;
  logic [3:0]  dmask;
  logic        lz_en;
  logic [3:0]  Dout;
  logic [3:0]  Eout;
  logic        frame_start;

  logic        rst8;
  logic        en8;
  logic [39:0] din8;
  logic [7:0]  dmask8;
  logic        lz8;
  logic [4:0]  Dout8;
  logic [7:0]  Eout8;
  logic        fs8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_display_n #(.DIGITS(4), .DW(4), .DIV(4), .BLANK(1)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .dmask(dmask), .lz_en(lz_en),
    .Dout(Dout), .Eout(Eout), .frame_start(frame_start)
  );

  scan_display_n #(.DIGITS(8), .DW(5), .DIV(3), .BLANK(2)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .din(din8), .dmask(dmask8), .lz_en(lz8),
    .Dout(Dout8), .Eout(Eout8), .frame_start(fs8)
  );

  typedef struct {
    string       name;
    logic [15:0] din;
    logic [3:0]  dmask;
    logic        lz;
    logic [15:0] se;   // Eout during lit cycles of slot s at se[s*4 +: 4]
    logic [15:0] sd;   // Dout during lit cycles of slot s at sd[s*4 +: 4]
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // hold reset for one edge, check the reset state, release with en high
  task automatic reset_dut(input logic [15:0] d, input logic [3:0] m, input logic lz);
    rst   = 1'b1;
    en    = 1'b0;
    din   = d;
    dmask = m;
    lz_en = lz;
    #1;
    step();
    chk("rst_eout", Eout, 4'hF);
    chk("rst_dout", Dout, 4'h0);
    chk("rst_fs", frame_start, 1'b0);
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ee;
    logic [3:0] ed;
    logic [7:0] ee8;
    logic [4:0] ed8;
    logic [3:0] resume_e [7];
    logic [3:0] resume_d [7];

    rst = 1'b1; en = 1'b0; din = '0; dmask = '0; lz_en = 1'b0;
    rst8 = 1'b1; en8 = 1'b0; din8 = '0; dmask8 = '0; lz8 = 1'b0;

    vecs[0] = '{"basic",     16'h3210, 4'hF,    1'b0, {4'b1110, 4'b1101, 4'b1011, 4'b0111}, 16'h3210};
    vecs[1] = '{"lz_0050",   16'h0050, 4'hF,    1'b1, {4'b1111, 4'b1111, 4'b1011, 4'b0111}, 16'h0050};
    vecs[2] = '{"lz_zero",   16'h0000, 4'hF,    1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b0111}, 16'h0000};
    vecs[3] = '{"mask_1010", 16'h1234, 4'b1010, 1'b0, {4'b1110, 4'b1111, 4'b1011, 4'b1111}, 16'h1030};
    vecs[4] = '{"lz_inner0", 16'h0A03, 4'hF,    1'b1, {4'b1111, 4'b1101, 4'b1011, 4'b0111}, 16'h0A03};
    vecs[5] = '{"lz_mask",   16'h0040, 4'b0110, 1'b1, {4'b1111, 4'b1111, 4'b1011, 4'b1111}, 16'h0040};

    // table-driven frames: two full frames per vector
    for (int v = 0; v < 6; v++) begin
      reset_dut(vecs[v].din, vecs[v].dmask, vecs[v].lz);
      for (int i = 0; i < 32; i++) begin
        step();
        if (i % 4 == 0) begin
          ee = 4'hF;
          ed = 4'h0;
        end else begin
          ee = vecs[v].se[((i / 4) % 4) * 4 +: 4];
          ed = vecs[v].sd[((i / 4) % 4) * 4 +: 4];
        end
        chk($sformatf("%s_eout_c%0d", vecs[v].name, i), Eout, ee);
        chk($sformatf("%s_dout_c%0d", vecs[v].name, i), Dout, ed);
        chk($sformatf("%s_fs_c%0d", vecs[v].name, i), frame_start, (i % 16 == 0));
      end
    end

    // coherence: din changes mid-frame, visible only after next snapshot
    reset_dut(16'h1111, 4'hF, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step();
      if (i % 4 != 0) chk($sformatf("coh_dout_c%0d", i), Dout, (i < 16) ? 4'h1 : 4'h2);
      if (i == 5) din = 16'h2222;
    end

    // enable freeze in slot 2 and resume from the frozen position
    reset_dut(16'h3210, 4'hF, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("frz_pre_eout", Eout, 4'b1101);
    en = 1'b0;
    step();
    chk("frz_eout", Eout, 4'hF);
    chk("frz_dout", Dout, 4'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("frz_hold_eout_c%0d", i), Eout, 4'hF);
      chk($sformatf("frz_hold_fs_c%0d", i), frame_start, 1'b0);
    end
    en = 1'b1;
    resume_e = '{4'b1101, 4'b1101, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111};
    resume_d = '{4'h2, 4'h2, 4'h0, 4'h3, 4'h3, 4'h3, 4'h0};
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("res_eout_c%0d", i), Eout, resume_e[i]);
      chk($sformatf("res_dout_c%0d", i), Dout, resume_d[i]);
      chk($sformatf("res_fs_c%0d", i), frame_start, (i == 6));
    end

    // asynchronous reset between clock edges
    reset_dut(16'h3210, 4'hF, 1'b0);
    step();
    chk("arst_pre_fs", frame_start, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_fs", frame_start, 1'b0);
    chk("arst_eout0", Eout, 4'hF);
    rst = 1'b0;
    step();
    chk("arst_rel_fs", frame_start, 1'b1);
    chk("arst_rel_eout", Eout, 4'hF);
    step();
    chk("arst_rel_fs2", frame_start, 1'b0);
    chk("arst_rel_lit", Eout, 4'b0111);
    for (int i = 0; i < 4; i++) step();
    chk("arst_pre_eout", Eout, 4'b1011);
    chk("arst_pre_dout", Dout, 4'h1);
    #3 rst = 1'b1;
    #1;
    chk("arst_eout", Eout, 4'hF);
    chk("arst_dout", Dout, 4'h0);
    chk("arst_fs2", frame_start, 1'b0);
    rst = 1'b0;

    // 8-digit / 5-bit / DIV=3 / BLANK=2 instance
    for (int j = 0; j < 8; j++) din8[j*5 +: 5] = 5'(j + 1);
    dmask8 = 8'hFF;
    step();
    chk("p8_rst_eout", Eout8, 8'hFF);
    chk("p8_rst_dout", Dout8, 5'd0);
    chk("p8_rst_fs", fs8, 1'b0);
    rst8 = 1'b0;
    en8  = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step();
      if (i % 3 == 2) begin
        ee8 = ~(8'h80 >> ((i / 3) % 8));
        ed8 = 5'((i / 3) % 8 + 1);
      end else begin
        ee8 = 8'hFF;
        ed8 = 5'd0;
      end
      chk($sformatf("p8_eout_c%0d", i), Eout8, ee8);
      chk($sformatf("p8_dout_c%0d", i), Dout8, ed8);
      chk($sformatf("p8_fs_c%0d", i), fs8, (i % 24 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
